// File: rtl/bk_pipelined_addsub.sv
// Brent-Kung adder/subtractor with valid/ready flow control.
// Bitwise G/P is registered first, the 2*log2(WIDTH)-1 prefix levels are
// spread over the middle register ranks, and the last rank holds S/Cout/Ovf.
module bk_pipelined_addsub #(
  parameter int WIDTH   = 16,
  parameter int STAGES  = 2,
  parameter int VALENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int LOG2W  = $clog2(WIDTH);
  localparam int LEVELS = 2 * LOG2W - 1;

  if (VALENCY != 2) begin : g_bad_valency
    $error("bk_pipelined_addsub: only VALENCY=2 is supported");
  end
  if ((WIDTH < 4) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("bk_pipelined_addsub: WIDTH must be a power of two in 4..64");
  end
  if ((STAGES < 1) || (STAGES > 2 * LOG2W)) begin : g_bad_stages
    $error("bk_pipelined_addsub: STAGES must be in 1..2*log2(WIDTH)");
  end

  // One Brent-Kung level: levels 0..LOG2W-1 are the up-sweep, the rest the
  // down-sweep that fills in the remaining prefixes.
  function automatic logic [2*WIDTH-1:0] prefix_level(
    input logic [WIDTH-1:0] g,
    input logic [WIDTH-1:0] p,
    input int               lvl
  );
    logic [WIDTH-1:0] go, po;
    logic [LOG2W-1:0] di, si;
    int d, src;
    bit hit;
    go = g;
    po = p;
    if (lvl < LOG2W) d = 1 << lvl;
    else             d = 1 << (2 * LOG2W - 2 - lvl);
    for (int i = 0; i < WIDTH; i++) begin
      src = i - d;
      di  = i[LOG2W-1:0];
      si  = src[LOG2W-1:0];
      if (lvl < LOG2W) hit = (((i + 1) % (2 * d)) == 0);
      else             hit = (i >= 3 * d - 1) && (((i + 1 - 3 * d) % (2 * d)) == 0);
      if (hit) begin
        go[di] = g[di] | (p[di] & g[si]);
        po[di] = p[di] & p[si];
      end
    end
    return {go, po};
  endfunction

  // Whether a register rank sits after node j (node 0 = bitwise G/P,
  // node k = after prefix level k). Earlier segments get the larger share.
  function automatic bit reg_after(input int j);
    int m, acc;
    bit r;
    r = 1'b0;
    if (STAGES >= 2) begin
      if (j == 0) r = 1'b1;
      m   = STAGES - 1;
      acc = 0;
      for (int s = 0; s < m - 1; s++) begin
        acc += LEVELS / m + ((s < LEVELS % m) ? 1 : 0);
        if (acc == j) r = 1'b1;
      end
    end
    return r;
  endfunction

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv | rst;

  for (genvar j = 0; j <= LEVELS; j++) begin : g_lv
    logic [WIDTH-1:0] cg, cp, cx;
    logic             cc, cv;
    logic [WIDTH-1:0] og, op, ox;
    logic             oc, ov;

    if (j == 0) begin : g_bit
      logic [WIDTH-1:0] b_eff;
      assign b_eff = sub ? ~B : B;
      assign cg    = A & b_eff;
      assign cp    = A | b_eff;
      assign cx    = A ^ b_eff;
      assign cc    = sub | Cin;
      assign cv    = in_valid;
    end else begin : g_pfx
      logic [WIDTH-1:0]   gi;
      logic [2*WIDTH-1:0] r;
      if (j == 1) begin : g_fold
        // Fold the carry-in into bit 0 so every group G already includes it.
        assign gi = {g_lv[0].og[WIDTH-1:1], g_lv[0].og[0] | (g_lv[0].op[0] & g_lv[0].oc)};
      end else begin : g_nofold
        assign gi = g_lv[j-1].og;
      end
      assign r  = prefix_level(gi, g_lv[j-1].op, j - 1);
      assign cg = r[2*WIDTH-1:WIDTH];
      assign cp = r[WIDTH-1:0];
      assign cx = g_lv[j-1].ox;
      assign cc = g_lv[j-1].oc;
      assign cv = g_lv[j-1].ov;
    end

    if (reg_after(j)) begin : g_reg
      // Pipeline rank after this node; shifts with its valid bit on adv.
      always_ff @(posedge clk) begin
        if (rst) begin
          og <= '0;
          op <= '0;
          ox <= '0;
          oc <= 1'b0;
          ov <= 1'b0;
        end else if (adv) begin
          og <= cg;
          op <= cp;
          ox <= cx;
          oc <= cc;
          ov <= cv;
        end
      end
    end else begin : g_wire
      assign og = cg;
      assign op = cp;
      assign ox = cx;
      assign oc = cc;
      assign ov = cv;
    end
  end

  logic [WIDTH-1:0] carry, s_c;
  logic             cout_c, ovf_c;
  logic             unused_p;

  assign carry    = {g_lv[LEVELS].og[WIDTH-2:0], g_lv[LEVELS].oc};
  assign s_c      = g_lv[LEVELS].ox ^ carry;
  assign cout_c   = g_lv[LEVELS].og[WIDTH-1];
  assign ovf_c    = carry[WIDTH-1] ^ cout_c;
  assign unused_p = ^g_lv[LEVELS].op;

  // Output rank: result and its valid bit, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      S         <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= g_lv[LEVELS].ov;
      S         <= s_c;
      Cout      <= cout_c;
      Ovf       <= ovf_c;
    end
  end

endmodule
